area_access_tracker: RTL



---
 rtl/area_access_pkg.sv | 35 +++
 rtl/area_list_scanner.sv | 105 ++++++++++
 rtl/area_access_tracker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/area_access_pkg.sv
// Purpose : shared constants and types for the area occupancy tracker.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: default geometry, command mode encodings, list-scan state type,
//           and small width helpers used to size the bitmap and counters.
package area_access_pkg;

  // Default geometry: 4 areas of 16 users each, no extra capacity limit.
  localparam int DEF_AREA_BITS = 2;
  localparam int DEF_USER_BITS = 4;
  localparam int DEF_CAPACITY  = 1 << DEF_USER_BITS;

  // Command encodings carried on the mode input.
  localparam logic [1:0] MODE_EXIT   = 2'b00;
  localparam logic [1:0] MODE_ENTER  = 2'b01;
  localparam logic [1:0] MODE_SEARCH = 2'b10;
  localparam logic [1:0] MODE_LIST   = 2'b11;

  // List scanner states.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Number of entries addressed by a field of the given width.
  function automatic int num_of(input int bits);
    return 1 << bits;
  endfunction

  // Width of a packed {area, user} identifier.
  function automatic int id_width(input int area_bits, input int user_bits);
    return area_bits + user_bits;
  endfunction

endpackage

// File: rtl/area_list_scanner.sv
// Purpose : walks the presence vector of one area, streaming each occupant.
// Latency : index 0 is presented the cycle after start; one index per cycle;
//           done pulses the cycle after the last index.
// Backpressure: none downstream; busy is high for the whole scan so the
//           command side can refuse new requests.
// Ports:
//   clk, rst_n      clock and async active-low reset
//   start_i         begin a scan (only honoured while idle)
//   area_i          area to scan (latched at start)
//   vec_i           presence vector of the area being scanned
//   idx_o           index currently presented
//   list_valid_o    list_out_o holds an occupant this cycle
//   list_out_o      {area, index} of the occupant
//   list_done_o     one-cycle pulse after the last index
//   busy_o          scan in progress
module area_list_scanner
  import area_access_pkg::*;
#(
  parameter int AREA_BITS = DEF_AREA_BITS,
  parameter int USER_BITS = DEF_USER_BITS
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start_i,
  input  logic [AREA_BITS-1:0]                    area_i,
  input  logic [num_of(USER_BITS)-1:0]            vec_i,
  output logic [USER_BITS-1:0]                    idx_o,
  output logic                                    list_valid_o,
  output logic [id_width(AREA_BITS,USER_BITS)-1:0] list_out_o,
  output logic                                    list_done_o,
  output logic                                    busy_o
);

  localparam int ID_W = id_width(AREA_BITS, USER_BITS);
  localparam logic [USER_BITS-1:0] LAST_IDX = '1;

  scan_state_e          state_q, state_d;
  logic [USER_BITS-1:0] idx_q, idx_d;
  logic [AREA_BITS-1:0] area_q, area_d;
  logic                 valid_q, valid_d;
  logic [ID_W-1:0]      out_q, out_d;
  logic                 done_q, done_d;
  logic [USER_BITS-1:0] idx_nxt;

  assign idx_nxt = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    area_d  = area_q;
    valid_d = 1'b0;
    out_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Index 0 is evaluated on the accepting edge so the scan spans
          // exactly 2**USER_BITS busy cycles.
          state_d = SCAN;
          idx_d   = '0;
          area_d  = area_i;
          valid_d = vec_i[0];
          out_d   = vec_i[0] ? {area_i, {USER_BITS{1'b0}}} : '0;
        end
      end
      SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_nxt;
          valid_d = vec_i[idx_nxt];
          out_d   = vec_i[idx_nxt] ? {area_q, idx_nxt} : '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      area_q  <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      area_q  <= area_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign idx_o        = idx_q;
  assign list_valid_o = valid_q;
  assign list_out_o   = out_q;
  assign list_done_o  = done_q;
  assign busy_o       = (state_q == SCAN);

endmodule

// File: rtl/area_access_tracker.sv
// Purpose : per-area occupancy bitmap and headcount with capacity limit,
//           presence search and sequential occupant listing.
// Latency : all outputs registered, updated on the accepting edge.
// Backpressure: busy high during a list scan; requests then are dropped.
// Ports:
//   clk, rst_n               clock and async active-low reset
//   req_valid, mode, userID  command strobe, opcode, {area, user}
//   busy                     list scan running
//   selectedAreaId           area of the last accepted command
//   numberOfInsideUser       post-command headcount of that area
//   AlreadyInside/NotInside/AreaFull  result flags of the last command
//   listOutput/listValid/listDone     occupant stream from a list command
module area_access_tracker
  import area_access_pkg::*;
#(
  parameter int AREA_BITS = DEF_AREA_BITS,
  parameter int USER_BITS = DEF_USER_BITS,
  parameter int CAPACITY  = DEF_CAPACITY
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  input  logic [1:0]                     mode,
  input  logic [AREA_BITS+USER_BITS-1:0] userID,
  output logic                           busy,
  output logic [AREA_BITS-1:0]           selectedAreaId,
  output logic [USER_BITS:0]             numberOfInsideUser,
  output logic                           AlreadyInside,
  output logic                           NotInside,
  output logic                           AreaFull,
  output logic [AREA_BITS+USER_BITS-1:0] listOutput,
  output logic                           listValid,
  output logic                           listDone
);

  localparam int NUM_AREAS = num_of(AREA_BITS);
  localparam int NUM_USERS = num_of(USER_BITS);
  localparam int ID_W      = id_width(AREA_BITS, USER_BITS);
  localparam int CNT_W     = USER_BITS + 1;
  localparam logic [CNT_W-1:0] CAP_CNT = CAPACITY[CNT_W-1:0];

  logic [NUM_AREAS-1:0][NUM_USERS-1:0] presence_q, presence_d;
  logic [NUM_AREAS-1:0][CNT_W-1:0]     count_q, count_d;

  logic [AREA_BITS-1:0] sel_q, sel_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic                 ai_q, ai_d;
  logic                 ni_q, ni_d;
  logic                 af_q, af_d;

  logic [AREA_BITS-1:0] cmd_area;
  logic [USER_BITS-1:0] cmd_user;
  logic                 cmd_hit;
  logic [CNT_W-1:0]     cmd_cnt;
  logic                 accept;
  logic                 scan_busy;
  logic                 scan_start;
  logic [NUM_USERS-1:0] scan_vec;
  logic [USER_BITS-1:0] scan_idx_unused;

  assign cmd_area = userID[ID_W-1:USER_BITS];
  assign cmd_user = userID[USER_BITS-1:0];
  assign cmd_hit  = presence_q[cmd_area][cmd_user];
  assign cmd_cnt  = count_q[cmd_area];
  assign accept   = req_valid && !scan_busy;
  assign scan_start = accept && (mode == MODE_LIST);

  // While scanning, the listed area is the last accepted one; the bitmap
  // cannot change then because every request is refused.
  assign scan_vec = presence_q[scan_busy ? sel_q : cmd_area];

  always_comb begin
    presence_d = presence_q;
    count_d    = count_q;
    sel_d      = sel_q;
    num_d      = num_q;
    ai_d       = ai_q;
    ni_d       = ni_q;
    af_d       = af_q;
    if (accept) begin
      sel_d = cmd_area;
      num_d = cmd_cnt;
      ai_d  = 1'b0;
      ni_d  = 1'b0;
      af_d  = 1'b0;
      case (mode)
        MODE_ENTER: begin
          if (cmd_hit) begin
            ai_d = 1'b1;
          end else if (cmd_cnt == CAP_CNT) begin
            af_d = 1'b1;
          end else begin
            presence_d[cmd_area][cmd_user] = 1'b1;
            count_d[cmd_area] = cmd_cnt + 1'b1;
            num_d             = cmd_cnt + 1'b1;
          end
        end
        MODE_EXIT: begin
          if (!cmd_hit) begin
            ni_d = 1'b1;
          end else begin
            presence_d[cmd_area][cmd_user] = 1'b0;
            count_d[cmd_area] = cmd_cnt - 1'b1;
            num_d             = cmd_cnt - 1'b1;
          end
        end
        MODE_SEARCH: begin
          ai_d = cmd_hit;
          ni_d = !cmd_hit;
        end
        default: begin
          // List: report the headcount only; the scanner does the rest.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presence_q <= '0;
      count_q    <= '0;
      sel_q      <= '0;
      num_q      <= '0;
      ai_q       <= 1'b0;
      ni_q       <= 1'b0;
      af_q       <= 1'b0;
    end else begin
      presence_q <= presence_d;
      count_q    <= count_d;
      sel_q      <= sel_d;
      num_q      <= num_d;
      ai_q       <= ai_d;
      ni_q       <= ni_d;
      af_q       <= af_d;
    end
  end

  area_list_scanner #(
    .AREA_BITS (AREA_BITS),
    .USER_BITS (USER_BITS)
  ) u_scanner (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (scan_start),
    .area_i       (cmd_area),
    .vec_i        (scan_vec),
    .idx_o        (scan_idx_unused),
    .list_valid_o (listValid),
    .list_out_o   (listOutput),
    .list_done_o  (listDone),
    .busy_o       (scan_busy)
  );

  assign busy               = scan_busy;
  assign selectedAreaId     = sel_q;
  assign numberOfInsideUser = num_q;
  assign AlreadyInside      = ai_q;
  assign NotInside          = ni_q;
  assign AreaFull           = af_q;

endmodule
